// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared 1-bit channel.
// Grants are registered; the data mux follows the grant combinationally.
module mux_arbiter #(
    parameter int MAXHOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic a,
    input  logic b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sl,
    output logic out,
    output logic valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    // last owner encoding: 0 = A, 1 = B
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // hold_cnt value on the final cycle of a fair share
    localparam logic [3:0] LAST_CNT = 4'(MAXHOLD - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic       share_done;
    logic       pick_a;

    assign share_done = (hold_cnt_q == LAST_CNT);

    // Contention from IDLE goes to whoever did not own last.
    assign pick_a = (last_q == OWN_B);

    // State, owner history and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= OWN_B;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state: arbitration, handover and fair-share enforcement.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                hold_cnt_d = 4'd0;
                unique case (1'b1)
                    (req_a && req_b): begin
                        state_d = pick_a ? GNT_A : GNT_B;
                        last_d  = pick_a ? OWN_A : OWN_B;
                    end
                    (req_a && !req_b): begin
                        state_d = GNT_A;
                        last_d  = OWN_A;
                    end
                    (!req_a && req_b): begin
                        state_d = GNT_B;
                        last_d  = OWN_B;
                    end
                    default: state_d = IDLE;
                endcase
            end
            GNT_A: begin
                if (!req_a || (req_b && share_done)) begin
                    state_d    = req_b ? GNT_B : IDLE;
                    last_d     = req_b ? OWN_B : last_q;
                    hold_cnt_d = 4'd0;
                end else if (share_done) begin
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            GNT_B: begin
                if (!req_b || (req_a && share_done)) begin
                    state_d    = req_a ? GNT_A : IDLE;
                    last_d     = req_a ? OWN_A : last_q;
                    hold_cnt_d = 4'd0;
                end else if (share_done) begin
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = 4'd0;
            end
        endcase
    end

    // Channel outputs decoded from the registered state.
    always_comb begin
        gnt_a = (state_q == GNT_A);
        gnt_b = (state_q == GNT_B);
        sl    = gnt_b;
        valid = gnt_a | gnt_b;
        out   = 1'b0;
        if (sl) begin
            out = b;
        end else if (gnt_a) begin
            out = a;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized and directed bench for mux_arbiter.
// Two instances (MAXHOLD 4 and 1) share stimulus against an owner model.
module tb_mux_arbiter;

    logic clk = 1'b0;
    logic rst, req_a, req_b, a, b;
    logic ga4, gb4, sl4, o4, v4;
    logic ga1, gb1, sl1, o1, v1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // model per instance: owner 0=none 1=A 2=B, run = cycles owned so far
    int own [2];
    int run [2];
    int lst [2];
    int mh  [2];

    always #5 clk = ~clk;

    mux_arbiter #(.MAXHOLD(4)) u4 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .a(a), .b(b), .gnt_a(ga4), .gnt_b(gb4), .sl(sl4),
        .out(o4), .valid(v4)
    );

    mux_arbiter #(.MAXHOLD(1)) u1 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .a(a), .b(b), .gnt_a(ga1), .gnt_b(gb1), .sl(sl1),
        .out(o1), .valid(v1)
    );

    task automatic check(input string tag,
                         input logic [4:0] obs,
                         input logic [4:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // {gnt_a, gnt_b, sl, out, valid} expected for a given owner
    function automatic logic [4:0] exp_bits(int o, logic da, logic db);
        logic d;
        d = (o == 1) ? da : (o == 2) ? db : 1'b0;
        return {o == 1, o == 2, o == 2, d, o != 0};
    endfunction

    // One clock edge of the arbitration rules, for instance i.
    task automatic model_edge(int i);
        int mine, other, o;
        logic rm, ro;
        if (rst) begin
            own[i] = 0; run[i] = 0; lst[i] = 2;
            return;
        end
        o = own[i];
        if (o == 0) begin
            if (req_a && req_b) o = (lst[i] == 2) ? 1 : 2;
            else if (req_a)     o = 1;
            else if (req_b)     o = 2;
            if (o != 0) begin
                own[i] = o; run[i] = 1; lst[i] = o;
            end
            return;
        end
        mine  = o;
        other = 3 - o;
        rm = (o == 1) ? req_a : req_b;
        ro = (o == 1) ? req_b : req_a;
        if (!rm || (ro && run[i] == mh[i])) begin
            if (ro) begin
                own[i] = other; run[i] = 1; lst[i] = other;
            end else begin
                own[i] = 0; run[i] = 0;
            end
        end else begin
            own[i] = mine;
            run[i] = (run[i] == mh[i]) ? 1 : run[i] + 1;
        end
    endtask

    // Advance one clock, check both instances, then re-check after
    // scrambling the data inputs (out must follow only the owner).
    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check("m4", {ga4, gb4, sl4, o4, v4}, exp_bits(own[0], a, b));
        check("m1", {ga1, gb1, sl1, o1, v1}, exp_bits(own[1], a, b));
        a = 1'($urandom);
        b = 1'($urandom);
        #1;
        check("m4d", {ga4, gb4, sl4, o4, v4}, exp_bits(own[0], a, b));
        check("m1d", {ga1, gb1, sl1, o1, v1}, exp_bits(own[1], a, b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        mh[0] = 4; mh[1] = 1;
        own[0] = 0; own[1] = 0;
        run[0] = 0; run[1] = 0;
        lst[0] = 2; lst[1] = 2;
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1; a = 1'b1; b = 1'b1;

        // reset wins over pending requests
        @(negedge clk);
        do_reset();
        check("rst4", {ga4, gb4, sl4, o4, v4}, 5'b00000);
        check("rst1", {ga1, gb1, sl1, o1, v1}, 5'b00000);

        // both held: A 1-4, B 5-8, A 9-12; MAXHOLD=1 alternates
        for (int c = 1; c <= 12; c++) begin
            cycle();
            check("fair_a4", {4'b0, ga4},
                  {4'b0, (c <= 4) || (c >= 9)});
            check("fair_sl4", {4'b0, sl4},
                  {4'b0, (c >= 5) && (c <= 8)});
            check("alt_a1", {4'b0, ga1}, {4'b0, c[0]});
            check("alt_sl1", {4'b0, sl1}, {4'b0, !c[0]});
        end

        // A alone for 10 cycles, data toggling: continuous grant
        req_b = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle();
            a = c[0];
            #1;
            check("solo_a", {ga4, gb4, sl4, o4, v4},
                  {3'b100, c[0], 1'b1});
        end

        // drop A while B asks: direct handover, no idle bubble
        req_a = 1'b0; req_b = 1'b1;
        cycle();
        check("handover", {ga4, gb4, sl4, v4}, 4'b0111);
        b = 1'b1;
        #1;
        check("handover_out", {4'b0, o4}, 5'b00001);

        // everyone drops: idle outputs stay low despite a=b=1
        req_a = 1'b0; req_b = 1'b0;
        cycle();
        a = 1'b1; b = 1'b1;
        #1;
        check("idle4", {ga4, gb4, sl4, o4, v4}, 5'b00000);
        check("idle1", {ga1, gb1, sl1, o1, v1}, 5'b00000);

        // reset during GNT_B at hold_cnt=2, then A wins first
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        for (int c = 0; c < 7; c++) cycle();
        check("pre_rst_b", {4'b0, gb4}, 5'b00001);
        do_reset();
        check("mid_rst", {ga4, gb4, sl4, o4, v4}, 5'b00000);
        cycle();
        check("post_rst_a", {4'b0, ga4}, 5'b00001);

        // random phase with sticky requests and rare resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            rst = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: MAXHOLD, default 4, maximum consecutive grant cycles per owner while the other requester waits; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_a  input  1  requester A wants the shared channel.
REQ-005 req_b  input  1  requester B wants the shared channel.
REQ-006 a  input  1  requester A data bit.
REQ-007 b  input  1  requester B data bit.
REQ-008 gnt_a  output  1  A owns the channel this cycle (registered).
REQ-009 gnt_b  output  1  B owns the channel this cycle (registered).
REQ-010 sl  output  1  mux select: 0 selects a, 1 selects b.
REQ-011 out  output  1  shared channel data.
REQ-012 valid  output  1  out carries granted data.

Function
REQ-013 FSM states SHALL be IDLE, GNT_A and GNT_B; gnt_a = (state==GNT_A), gnt_b = (state==GNT_B), at most one high.
REQ-014 sl SHALL be 1 only in GNT_B, 0 in IDLE and GNT_A.
REQ-015 out SHALL be combinational: a when sl=0 and gnt_a=1; b when sl=1; 0 in IDLE; valid = gnt_a | gnt_b.
REQ-016 Grant latency: a request sampled at edge N SHALL show a grant from edge N+1 on; no combinational req-to-gnt path.
REQ-017 IDLE, only one req high: go to that requester's GNT state.
REQ-018 IDLE, both req high: grant the requester not in register last (last=B means A wins).
REQ-019 last SHALL update to the new owner on every entry into GNT_A or GNT_B.
REQ-020 4-bit hold_cnt SHALL clear on every grant entry and increment each cycle the grant is held.
REQ-021 GNT_A, req_a low: go to GNT_B if req_b high, else IDLE; no idle bubble on handover.
REQ-022 GNT_A, req_a high, req_b high, hold_cnt == MAXHOLD-1: forced handover to GNT_B.
REQ-023 GNT_A, req_a high, req_b low, hold_cnt == MAXHOLD-1: stay in GNT_A, hold_cnt clears to 0 (no saturation, no wrap past MAXHOLD-1).
REQ-024 GNT_B SHALL mirror REQ-021..023 with A and B swapped.
REQ-025 MAXHOLD=1 with both req held SHALL alternate owner every cycle.
REQ-026 a/b changes while not granted SHALL NOT affect out.

Reset
REQ-027 rst high at an edge SHALL force state=IDLE, gnt_a=0, gnt_b=0, sl=0, out=0, valid=0, hold_cnt=0, last=B, regardless of requests.
REQ-028 rst asserted mid-grant SHALL drop the grant at that edge; first post-reset grant follows REQ-017/018 (A first on contention).
REQ-029 rst SHALL take priority over all transitions in the same cycle.

Verification
REQ-030 Reset, then req_a=req_b=1 held, MAXHOLD=4 -> gnt_a cycles 1-4, gnt_b cycles 5-8, gnt_a 9-12; sl 0,0,0,0,1,1,1,1.
REQ-031 req_a=1 only for 10 cycles, a toggling -> gnt_a continuous 10 cycles, out tracks a, hold_cnt wraps 3->0, gnt_b never set.
REQ-032 GNT_A, drop req_a with req_b=1 same cycle -> next edge gnt_b=1, sl=1, no IDLE cycle, out=b.
REQ-033 Both req low after grant -> IDLE: valid=0, out=0, sl=0 even with a=b=1.
REQ-034 rst pulsed during GNT_B at hold_cnt=2, both req high -> IDLE at that edge, gnt_a=1 one cycle after rst deasserts.
REQ-035 MAXHOLD=1, both req high -> gnt_a/gnt_b alternate every cycle; sl toggles 0,1,0,1.
